// File: rtl/fifo_ptr_ctrl_pkg.sv
// fifo_ptr_ctrl_pkg: shared FIFO sizing constants, mirroring the legacy para.h header
package fifo_ptr_ctrl_pkg;
  localparam int a_length = 3;
  localparam int depth = 1 << a_length;
endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: request/status bundle between the FIFO front end and the pointer engine
interface fifo_ptr_ctrl_if
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int A_LENGTH = a_length
);
  logic                wr_en;
  logic                rd_en;
  logic                clr_err;
  logic [A_LENGTH-1:0] wr_addr;
  logic [A_LENGTH-1:0] rd_addr;
  logic                MSB_wr_ptr;
  logic                MSB_rd_ptr;
  logic [A_LENGTH-1:0] ptr_diff;
  logic [A_LENGTH:0]   count;
  logic                wr_accept;
  logic                rd_accept;
  logic                overflow;
  logic                underflow;
  modport master (
    output wr_en, rd_en, clr_err,
    input  wr_addr, rd_addr, MSB_wr_ptr, MSB_rd_ptr, ptr_diff, count,
           wr_accept, rd_accept, overflow, underflow
  );
  modport slave (
    input  wr_en, rd_en, clr_err,
    output wr_addr, rd_addr, MSB_wr_ptr, MSB_rd_ptr, ptr_diff, count,
           wr_accept, rd_accept, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl_ptr_counter.sv
// ptr_counter: wrap-around pointer with enable; the extra MSB distinguishes full from empty
module ptr_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] ptr
);
  // advance by one per accepted access, wrapping naturally at 2^W
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: FIFO write/read pointer engine with occupancy and sticky error flags
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int A_LENGTH = a_length
) (
  input logic            clk,
  input logic            reset_n,
  fifo_ptr_ctrl_if.slave bus
);
  logic [A_LENGTH:0] wr_ptr;
  logic [A_LENGTH:0] rd_ptr;
  logic              full;
  logic              empty;
  logic              ovf_q;
  logic              unf_q;
  ptr_counter #(.W(A_LENGTH + 1)) u_wr (
    .clk(clk), .reset_n(reset_n), .en(bus.wr_accept), .ptr(wr_ptr)
  );
  ptr_counter #(.W(A_LENGTH + 1)) u_rd (
    .clk(clk), .reset_n(reset_n), .en(bus.rd_accept), .ptr(rd_ptr)
  );
  // status decode uses registered pointers only, so accepts never loop back on themselves
  always_comb begin
    bus.wr_addr    = wr_ptr[A_LENGTH-1:0];
    bus.rd_addr    = rd_ptr[A_LENGTH-1:0];
    bus.MSB_wr_ptr = wr_ptr[A_LENGTH];
    bus.MSB_rd_ptr = rd_ptr[A_LENGTH];
    bus.ptr_diff   = wr_ptr[A_LENGTH-1:0] - rd_ptr[A_LENGTH-1:0];
    bus.count      = wr_ptr - rd_ptr;
    empty          = (wr_ptr[A_LENGTH] == rd_ptr[A_LENGTH]) && bus.ptr_diff == '0;
    full           = (wr_ptr[A_LENGTH] != rd_ptr[A_LENGTH]) && bus.ptr_diff == '0;
    bus.wr_accept  = bus.wr_en & ~full & reset_n;
    bus.rd_accept  = bus.rd_en & ~empty & reset_n;
    bus.overflow   = ovf_q;
    bus.underflow  = unf_q;
  end
  // sticky error flags: a new illegal access beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en && full) ? 1'b1 : bus.clr_err ? 1'b0 : ovf_q;
      unf_q <= (bus.rd_en && empty) ? 1'b1 : bus.clr_err ? 1'b0 : unf_q;
    end
endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer and occupancy engine for the synchronous FIFO. It accepts write and read requests and advances wrap-around write and read pointers, each carrying an extra wrap MSB. It drives the memory addresses and produces the ptr_diff, MSB_wr_ptr and MSB_rd_ptr signals consumed by the FIFO status-flag logic. It also blocks illegal accesses and records sticky overflow and underflow errors.

Parameters:
A_LENGTH, 3, address width; FIFO depth = 2^A_LENGTH (default 8 entries).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request
rd_en  input  1  read request
clr_err  input  1  synchronous clear of overflow/underflow
wr_addr  output  A_LENGTH  memory write address = wr_ptr[A_LENGTH-1:0]
rd_addr  output  A_LENGTH  memory read address = rd_ptr[A_LENGTH-1:0]
MSB_wr_ptr  output  1  wr_ptr[A_LENGTH] (wrap bit)
MSB_rd_ptr  output  1  rd_ptr[A_LENGTH] (wrap bit)
ptr_diff  output  A_LENGTH  (wr_addr - rd_addr) mod 2^A_LENGTH
count  output  A_LENGTH+1  occupancy, 0..2^A_LENGTH
wr_accept  output  1  write takes effect at this edge (memory write enable)
rd_accept  output  1  read takes effect at this edge (memory read enable)
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- State: wr_ptr and rd_ptr registers, each A_LENGTH+1 bits; overflow and underflow flops. Nothing else is stored.
- Reset (reset_n=0, asynchronous): both pointers = 0 and overflow = underflow = 0.
  - Outputs therefore read: wr_addr = rd_addr = 0, MSBs = 0, ptr_diff = 0, count = 0, wr_accept = rd_accept = 0.
  - The reset takes effect immediately, without waiting for a clock edge, including mid-burst.
- Internal full/empty, decoded from registered pointers only (no combinational loop):
  - empty = (MSB_wr_ptr == MSB_rd_ptr) && ptr_diff == 0
  - full = (MSB_wr_ptr != MSB_rd_ptr) && ptr_diff == 0
- Accept rules (combinational, zero latency):
  - wr_accept = wr_en & ~full & reset_n
  - rd_accept = rd_en & ~empty & reset_n
  - Full blocks a write even when a read is accepted in the same cycle, and empty blocks a read even when a write is accepted. There is no pass-through.
- Pointer update at rising clk:
  - wr_ptr += 1 when wr_accept; rd_ptr += 1 when rd_accept.
  - Increment is modulo 2^(A_LENGTH+1): wr_addr wraps from 2^A_LENGTH-1 to 0 and the MSB toggles.
- Simultaneous accepted write and read: both pointers advance; count and ptr_diff are unchanged.
- count = (wr_ptr - rd_ptr) mod 2^(A_LENGTH+1), combinational from the registers. Full gives count = 2^A_LENGTH; empty gives 0.
- Error flags:
  - overflow sets at the edge where wr_en=1 && full; underflow sets at the edge where rd_en=1 && empty.
  - Both clear at an edge with clr_err=1. When set and clear coincide, set wins.
  - A blocked access leaves the pointers untouched.
- Latency: a pointer, ptr_diff or count change is visible one cycle after the accepted request. Flags derived downstream follow with the same 1-cycle latency.

Decomposition:
- The existing shared header (para.h) holds a_length, f_h_value, f_a_full and f_a_empty. A_LENGTH defaults from `a_length so the flag logic and this block agree on width.
- One natural sub-module, ptr_counter: an (A_LENGTH+1)-bit wrap counter with enable and async active-low reset. It is instantiated twice, for write and read.
- Full/empty decode, accept logic and the error flops stay inline.

Test Plan:
- Release reset, both enables idle -> count=0, ptr_diff=0, MSB_wr_ptr=MSB_rd_ptr=0, wr_accept=rd_accept=0, overflow=underflow=0.
- 8 consecutive writes -> after the 8th edge: wr_addr=0, MSB_wr_ptr=1, ptr_diff=0, count=8. A 9th wr_en gives wr_accept=0, overflow=1 after the edge, pointers unchanged.
- From full, 8 reads -> rd_addr sequence 0..7 then 0, MSB_rd_ptr=1, count=0. A 9th rd_en gives rd_accept=0 and underflow=1.
- Preload count=4, then wr_en=rd_en=1 for 20 cycles -> count stays 4, ptr_diff=4, both pointers wrap with MSB toggling, no error flags.
- With overflow=1, assert clr_err with wr_en while full -> overflow stays 1. Next cycle clr_err alone -> overflow=0.
- At count=5, drop reset_n between clock edges -> all outputs go to reset values before the next rising edge. After release, the first write lands at wr_addr=0.
